// File: rtl/simon_pkg.sv
// Shared game-controller definitions: BCD limits and the score converter state type.
package simon_pkg;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BCD_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter for the score display. It shifts one bit per
// cycle and holds the previous digits until a conversion completes.
module score_bcd_conv
    import simon_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter bit          CLK_EN_CONV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin,
    input  logic             force_req,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int unsigned SR_W = WIDTH + 16;

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("score_bcd_conv: WIDTH must lie in 4..16");
    end

    conv_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] last_bin_q, last_bin_d;
    logic             pend_q, pend_d;
    logic             ovf_next_q, ovf_next_d;
    logic [15:0]      digits_q, digits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      bcd_adj;
    logic [SR_W-1:0]  sr_shift;
    logic [WIDTH-1:0] sat_load;
    logic             saturate;
    logic             trigger;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr_q[WIDTH + 4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    // 9999 is left-aligned so that 14 shifts land it exactly in the BCD field.
    if (WIDTH >= 14) begin : g_sat
        assign sat_load = WIDTH'(BCD_MAX) << (WIDTH - 14);
    end else begin : g_no_sat
        assign sat_load = '0;
    end

    assign sr_shift = {bcd_adj, sr_q[WIDTH-1:0]} << 1;
    assign saturate = 32'(bin) > BCD_MAX;
    assign trigger  = force_req | pend_q | (CLK_EN_CONV && (bin != last_bin_q));

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        last_bin_d = last_bin_q;
        pend_d     = pend_q;
        ovf_next_d = ovf_next_q;
        digits_d   = digits_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        if (force_req && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = SHIFT;
                    busy_d     = 1'b1;
                    last_bin_d = bin;
                    pend_d     = 1'b0;
                    ovf_next_d = saturate;
                    if (saturate) begin
                        sr_d  = {16'b0, sat_load};
                        cnt_d = 5'd14;
                    end else begin
                        sr_d  = {16'b0, bin};
                        cnt_d = 5'(WIDTH);
                    end
                end
            end
            SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    digits_d = sr_shift[SR_W-1 -: 16];
                    ovf_d    = ovf_next_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            last_bin_q <= '0;
            pend_q     <= 1'b0;
            ovf_next_q <= 1'b0;
            digits_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            last_bin_q <= last_bin_d;
            pend_q     <= pend_d;
            ovf_next_q <= ovf_next_d;
            digits_q   <= digits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign thousands = digits_q[15:12];
    assign hundreds  = digits_q[11:8];
    assign tens      = digits_q[7:4];
    assign ones      = digits_q[3:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// Bench for score_bcd_conv: three instances (WIDTH 10, 14, and 8 without change detection).
module tb_score_bcd_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [9:0]  a_bin;
    logic        a_force, a_busy, a_done, a_ovf;
    logic [3:0]  a_ones, a_tens, a_hund, a_thou;
    logic [13:0] b_bin;
    logic        b_force, b_busy, b_done, b_ovf;
    logic [3:0]  b_ones, b_tens, b_hund, b_thou;
    logic [7:0]  c_bin;
    logic        c_force, c_busy, c_done, c_ovf;
    logic [3:0]  c_ones, c_tens, c_hund, c_thou;

    int checks = 0;
    int errors = 0;

    score_bcd_conv #(.WIDTH(10), .CLK_EN_CONV(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .bin(a_bin), .force_req(a_force),
        .ones(a_ones), .tens(a_tens), .hundreds(a_hund), .thousands(a_thou),
        .busy(a_busy), .done(a_done), .ovf(a_ovf)
    );

    score_bcd_conv #(.WIDTH(14), .CLK_EN_CONV(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .bin(b_bin), .force_req(b_force),
        .ones(b_ones), .tens(b_tens), .hundreds(b_hund), .thousands(b_thou),
        .busy(b_busy), .done(b_done), .ovf(b_ovf)
    );

    score_bcd_conv #(.WIDTH(8), .CLK_EN_CONV(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .bin(c_bin), .force_req(c_force),
        .ones(c_ones), .tens(c_tens), .hundreds(c_hund), .thousands(c_thou),
        .busy(c_busy), .done(c_done), .ovf(c_ovf)
    );

    // Reference: saturate at 9999 and split into decimal digits arithmetically.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int ref_latency(input int unsigned v, input int unsigned w);
        return ((v > 9999) ? 14 : int'(w)) + 1;
    endfunction

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        a_bin = '0; a_force = 1'b0;
        b_bin = '0; b_force = 1'b0;
        c_bin = '0; c_force = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({a_thou, a_hund, a_tens, a_ones, a_busy, a_done, a_ovf} !== 19'b0) begin
            errors++;
            $display("FAIL reset_a got=%h/%b%b%b exp=0000/000", {a_thou, a_hund, a_tens, a_ones},
                     a_busy, a_done, a_ovf);
        end
        checks++;
        if ({b_thou, b_hund, b_tens, b_ones, b_busy, b_done, b_ovf} !== 19'b0) begin
            errors++;
            $display("FAIL reset_b got=%h/%b%b%b exp=0000/000", {b_thou, b_hund, b_tens, b_ones},
                     b_busy, b_done, b_ovf);
        end
        checks++;
        if ({c_thou, c_hund, c_tens, c_ones, c_busy, c_done, c_ovf} !== 19'b0) begin
            errors++;
            $display("FAIL reset_c got=%h/%b%b%b exp=0000/000", {c_thou, c_hund, c_tens, c_ones},
                     c_busy, c_done, c_ovf);
        end
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            seen = seen | a_busy | a_done | b_busy | b_done | c_busy | c_done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle busy_or_done_seen=%b exp=0", seen);
        end
        checks++;
        if ({a_thou, a_hund, a_tens, a_ones} !== 16'h0000) begin
            errors++;
            $display("FAIL zero_digits got=%h exp=0000", {a_thou, a_hund, a_tens, a_ones});
        end
    endtask

    task automatic test_single_1023();
        a_bin = 10'd1023;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            tick();
            checks++;
            if (a_busy !== (cyc <= 11)) begin
                errors++;
                $display("FAIL busy_1023 cyc=%0d got=%b exp=%b", cyc, a_busy, cyc <= 11);
            end
            checks++;
            if (a_done !== (cyc == 11)) begin
                errors++;
                $display("FAIL done_1023 cyc=%0d got=%b exp=%b", cyc, a_done, cyc == 11);
            end
            if (cyc == 11) begin
                checks++;
                if ({a_thou, a_hund, a_tens, a_ones, a_ovf} !== {ref_bcd(1023), 1'b0}) begin
                    errors++;
                    $display("FAIL digits_1023 got=%h ovf=%b exp=%h ovf=0",
                             {a_thou, a_hund, a_tens, a_ones}, a_ovf, ref_bcd(1023));
                end
            end
        end
    endtask

    task automatic test_mid_change();
        int          dcyc[$];
        logic [15:0] ddig[$];
        a_bin = 10'd5;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (a_done) begin
                dcyc.push_back(cyc);
                ddig.push_back({a_thou, a_hund, a_tens, a_ones});
            end
            if (cyc == 4) a_bin = 10'd37;
        end
        checks++;
        if (dcyc.size() != 2) begin
            errors++;
            $display("FAIL mid_change_count got=%0d exp=2", dcyc.size());
        end else begin
            checks++;
            if (dcyc[0] != 11 || ddig[0] !== ref_bcd(5)) begin
                errors++;
                $display("FAIL mid_change_first got=cyc%0d/%h exp=cyc11/%h", dcyc[0], ddig[0],
                         ref_bcd(5));
            end
            checks++;
            if (dcyc[1] != 23 || ddig[1] !== ref_bcd(37)) begin
                errors++;
                $display("FAIL mid_change_second got=cyc%0d/%h exp=cyc23/%h", dcyc[1], ddig[1],
                         ref_bcd(37));
            end
        end
    endtask

    task automatic test_force();
        int          dcyc[$];
        logic [15:0] ddig[$];
        a_bin = 10'd512;
        for (int k = 0; k < 20 && !a_done; k++) tick();
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $display("FAIL force_setup done got=%b exp=1", a_done);
        end
        tick();
        a_force = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (a_done) begin
                dcyc.push_back(cyc);
                ddig.push_back({a_thou, a_hund, a_tens, a_ones});
            end
            a_force = (cyc == 3 || cyc == 6);
        end
        checks++;
        if (dcyc.size() != 2) begin
            errors++;
            $display("FAIL force_count got=%0d exp=2", dcyc.size());
        end else begin
            checks++;
            if (dcyc[0] != 11 || dcyc[1] != 23 || ddig[0] !== ref_bcd(512)
                || ddig[1] !== ref_bcd(512)) begin
                errors++;
                $display("FAIL force_pulses got=cyc%0d/%h,cyc%0d/%h exp=cyc11/%h,cyc23/%h",
                         dcyc[0], ddig[0], dcyc[1], ddig[1], ref_bcd(512), ref_bcd(512));
            end
        end
    endtask

    task automatic test_back_to_back();
        int dcyc[$];
        int exp_cyc;
        a_force = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            if (a_done) dcyc.push_back(cyc);
            if (cyc == 36) a_force = 1'b0;
        end
        checks++;
        if (dcyc.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=4", dcyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_cyc = (k + 1) * 12 - 1;
                checks++;
                if (dcyc[k] != exp_cyc) begin
                    errors++;
                    $display("FAIL b2b_cycle idx=%0d got=%0d exp=%0d", k, dcyc[k], exp_cyc);
                end
            end
        end
    endtask

    task automatic test_random_a();
        int unsigned last, v;
        int lat;
        last = 512;
        repeat (20) begin
            v = $urandom_range(1021, 0);
            if (v >= last) v++;
            a_bin = 10'(v);
            for (lat = 1; lat <= 20; lat++) begin
                tick();
                if (a_done) break;
            end
            checks++;
            if (lat != ref_latency(v, 10)
                || {a_thou, a_hund, a_tens, a_ones, a_ovf} !== {ref_bcd(v), 1'b0}) begin
                errors++;
                $display("FAIL rand_a v=%0d got=lat%0d/%h/ovf%b exp=lat%0d/%h/ovf0", v, lat,
                         {a_thou, a_hund, a_tens, a_ones}, a_ovf, ref_latency(v, 10), ref_bcd(v));
            end
            tick();
            last = v;
        end
    endtask

    task automatic test_ovf_b();
        int unsigned vals[$];
        int unsigned v;
        int lat;
        logic exp_ovf;
        vals.push_back(12345);
        vals.push_back(42);
        repeat (10) vals.push_back($urandom_range(16383, 0));
        foreach (vals[i]) begin
            v = vals[i];
            if (i > 0 && v == vals[i-1]) v = v ^ 1;
            vals[i] = v;
            b_bin = 14'(v);
            exp_ovf = (v > 9999);
            for (lat = 1; lat <= 25; lat++) begin
                tick();
                if (b_done) break;
            end
            checks++;
            if (lat != ref_latency(v, 14)
                || {b_thou, b_hund, b_tens, b_ones, b_ovf} !== {ref_bcd(v), exp_ovf}) begin
                errors++;
                $display("FAIL ovf_b v=%0d got=lat%0d/%h/ovf%b exp=lat%0d/%h/ovf%b", v, lat,
                         {b_thou, b_hund, b_tens, b_ones}, b_ovf, ref_latency(v, 14), ref_bcd(v),
                         exp_ovf);
            end
            tick();
            tick();
            checks++;
            if (b_ovf !== exp_ovf || b_busy !== 1'b0) begin
                errors++;
                $display("FAIL ovf_hold v=%0d got=ovf%b busy%b exp=ovf%b busy0", v, b_ovf,
                         b_busy, exp_ovf);
            end
        end
    endtask

    task automatic test_force_only_c();
        logic seen;
        int lat;
        c_bin = 8'd200;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen = seen | c_busy | c_done;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_auto_conv busy_or_done_seen=%b exp=0", seen);
        end
        c_force = 1'b1;
        for (lat = 1; lat <= 20; lat++) begin
            tick();
            c_force = 1'b0;
            if (c_done) break;
        end
        checks++;
        if (lat != ref_latency(200, 8) || {c_thou, c_hund, c_tens, c_ones} !== ref_bcd(200)) begin
            errors++;
            $display("FAIL force_only got=lat%0d/%h exp=lat%0d/%h", lat,
                     {c_thou, c_hund, c_tens, c_ones}, ref_latency(200, 8), ref_bcd(200));
        end
    endtask

    task automatic test_reset_mid();
        int          dcyc[$];
        logic [15:0] ddig[$];
        a_bin = 10'd1023;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (a_done) begin
                dcyc.push_back(cyc);
                ddig.push_back({a_thou, a_hund, a_tens, a_ones});
            end
            if (cyc == 6) begin
                checks++;
                if ({a_busy, a_thou, a_hund, a_tens, a_ones} !== 17'b0) begin
                    errors++;
                    $display("FAIL reset_mid got=busy%b/%h exp=busy0/0000", a_busy,
                             {a_thou, a_hund, a_tens, a_ones});
                end
            end
            rst = (cyc == 5);
        end
        // last_bin cleared to 0, so the held 1023 converts again right after reset.
        checks++;
        if (dcyc.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_done_count got=%0d exp=1", dcyc.size());
        end else begin
            checks++;
            if (dcyc[0] != 17 || ddig[0] !== ref_bcd(1023)) begin
                errors++;
                $display("FAIL reset_mid_reconv got=cyc%0d/%h exp=cyc17/%h", dcyc[0], ddig[0],
                         ref_bcd(1023));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_1023();
        test_mid_change();
        test_force();
        test_back_to_back();
        test_random_a();
        test_ovf_b();
        test_force_only_c();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
